pipe_ctrl_reg: RTL and testbench
================================

PIPE_CTRL_REG -- requirements
Module: pipe_ctrl_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the control-bundle width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 1, the number of register stages (1..4).
REQ-003 SHALL have parameter FLUSH_VAL, default '0, the WIDTH-bit bubble value loaded on flush or reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: advance enable; when low, the pipeline stalls.
REQ-007 SHALL have port flush, input, DEPTH bits: bit k kills stage k (stage 0 is nearest the input).
REQ-008 SHALL have port d, input, WIDTH bits: control bundle from the producing stage.
REQ-009 SHALL have port valid_d, input, 1 bit: d carries a real instruction.
REQ-010 SHALL have port q, output, WIDTH bits: the last stage's bundle.
REQ-011 SHALL have port valid_q, output, 1 bit: the last stage's valid bit.
REQ-012 SHALL have port stage_valid, output, DEPTH bits: the valid bit of every stage, for hazard logic.

Function
REQ-013 Each stage SHALL hold a WIDTH-bit data register and a 1-bit valid register.
REQ-014 With en=1 and no flush, on each rising clk edge stage 0 SHALL load {d, valid_d} and stage k SHALL load stage k-1, so latency from d to q is exactly DEPTH cycles.
REQ-015 With en=0, every stage not being flushed SHALL hold its data and valid bits unchanged.
REQ-016 When flush[k]=1, on the next edge stage k SHALL load data FLUSH_VAL and valid 0, regardless of en.
REQ-017 Flush SHALL take priority over both stall and advance for that stage only; other stages follow REQ-014/REQ-015.
REQ-018 Under en=1, a stage following a flushed stage SHALL receive the flushed stage's pre-edge contents; the bubble appears in stage k+1 one cycle later.
REQ-019 When valid is 0, the stage data SHALL equal FLUSH_VAL, so downstream write enables contained in the bundle are inert.
REQ-020 q and valid_q SHALL be driven directly from the last stage's registers, with no combinational path from d, en or flush.
REQ-021 stage_valid[k] SHALL reflect stage k's valid register.
REQ-022 DEPTH=1 SHALL behave as a single enabled register with flush[0] as a synchronous clear.

Reset
REQ-023 Asserting reset SHALL immediately, without waiting for clk, set all stage data to FLUSH_VAL and all valid bits to 0, so q=FLUSH_VAL, valid_q=0 and stage_valid=0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight bundles, and none SHALL reappear after release.
REQ-025 On the first edge after reset deasserts, the block SHALL obey REQ-014 to REQ-017.

Configuration
REQ-026 With macro PIPE_CTRL_STATS_EN defined, the block SHALL add outputs stall_cnt[15:0] and bubble_cnt[15:0].
REQ-027 stall_cnt SHALL increment on each edge with en=0 and valid_q=1.
REQ-028 bubble_cnt SHALL increment on each edge where valid_q=0 after the edge.
REQ-029 Both counters SHALL saturate at 16'hFFFF and SHALL be cleared by reset.
REQ-030 Without PIPE_CTRL_STATS_EN, the counters and their ports SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-031 A shared package pipe_pkg SHALL hold the ctrl_t typedef (pcsrc, regwrite, memtoreg, memwrite, branch, alusrc, flagwrite[1:0], alucontrol[2:0], cond[3:0]), the constant CTRL_W = $bits(ctrl_t) (16), and the constant CTRL_NOP.
REQ-032 One sub-module, pipe_stage, SHALL implement a single stage (data and valid registers with en, flush and reset), instantiated DEPTH times by a generate loop.

Verification
REQ-033 Advance test: DEPTH=2, en=1, drive d=16'h1234 with valid_d=1 at cycle 0, then 16'h00AB at cycle 1 -> q=16'h1234, valid_q=1 after edge 2, and q=16'h00AB after edge 3.
REQ-034 Stall test: DEPTH=1 holding 16'h5A5A, drive en=0 for 3 cycles while d changes to 16'hFFFF -> q stays 16'h5A5A; with en=1, q=16'hFFFF after the next edge.
REQ-035 Flush-over-stall test: DEPTH=2 holding valid bundles A (stage 0) and B (stage 1), en=0, flush=2'b01 -> stage 0 becomes FLUSH_VAL/0 while stage 1 holds B with valid_q=1; next edge with en=1 -> valid_q=0, q=FLUSH_VAL.
REQ-036 Async reset test: assert reset between clock edges while valid_q=1 -> q=FLUSH_VAL and valid_q=0 before the next edge; after release, the first valid output appears DEPTH edges after the first valid_d.
REQ-037 Stats saturation test (PIPE_CTRL_STATS_EN): preload stall_cnt to 16'hFFFE via force, then apply 3 stalled cycles with valid_q=1 -> stall_cnt=16'hFFFF; with the macro undefined, the design compiles with no stall_cnt port.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline control definitions.
//   ctrl_t    - decoded control bundle carried down the pipe
//   CTRL_W    - width of ctrl_t in bits (16)
//   CTRL_NOP  - all-zero bundle (every write enable inert)
//   sat_inc16 - saturating 16-bit increment used by the stats counters
package pipe_pkg;

    // 15 architectural control bits plus one spare bit that keeps the
    // bundle at a round 16 bits for the datapath registers.
    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] flagwrite;
        logic [2:0] alucontrol;
        logic [3:0] cond;
        logic       spare;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one control-pipeline stage (data + valid register).
//   clk, reset  - clock, async active-high reset
//   en          - advance; low holds the stage
//   flush       - loads the bubble (FLUSH_VAL / valid 0), beats en
//   d, valid_d  - bundle from the previous stage
//   q, valid_q  - registered bundle
module pipe_stage #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_d,
    output logic [WIDTH-1:0] q,
    output logic             valid_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= FLUSH_VAL;
            valid_q <= 1'b0;
        end else if (flush) begin
            q       <= FLUSH_VAL;
            valid_q <= 1'b0;
        end else if (en) begin
            // An invalid bundle is replaced by the bubble so that any write
            // enables it carries can never fire downstream.
            q       <= valid_d ? d : FLUSH_VAL;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_reg.sv
// pipe_ctrl_reg: DEPTH-stage pipeline register for control bundles with
// per-stage flush, global stall and async reset.
//   clk, reset          - clock, async active-high reset
//   en                  - advance enable (0 = stall)
//   flush[DEPTH-1:0]    - per-stage kill, bit 0 nearest the input
//   d, valid_d          - incoming bundle and its valid
//   q, valid_q          - last stage bundle / valid (pure register outputs)
//   stage_valid         - valid bit of every stage
//   stall_cnt, bubble_cnt - saturating stats, only with PIPE_CTRL_STATS_EN
// Optional feature macro: PIPE_CTRL_STATS_EN
module pipe_ctrl_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = CTRL_W,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DEPTH-1:0] flush,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_d,
    output logic [WIDTH-1:0] q,
    output logic             valid_q,
    output logic [DEPTH-1:0] stage_valid
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      bubble_cnt
`endif
);

    logic [DEPTH-1:0][WIDTH-1:0] sdata;
    logic [DEPTH-1:0]            vld_pipe;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] in_d;
        logic             in_v;
        if (k == 0) begin : g_head
            assign in_d = d;
            assign in_v = valid_d;
        end else begin : g_body
            assign in_d = sdata[k-1];
            assign in_v = vld_pipe[k-1];
        end

        pipe_stage #(.WIDTH(WIDTH), .FLUSH_VAL(FLUSH_VAL)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .flush   (flush[k]),
            .d       (in_d),
            .valid_d (in_v),
            .q       (sdata[k]),
            .valid_q (vld_pipe[k])
        );
    end

    assign q           = sdata[DEPTH-1];
    assign valid_q     = vld_pipe[DEPTH-1];
    assign stage_valid = vld_pipe;

`ifdef PIPE_CTRL_STATS_EN
    // Valid of the last stage as it will be after the coming edge; the
    // bubble counter scores the post-edge state.
    logic prev_vld;
    logic last_vld_nxt;

    if (DEPTH == 1) begin : g_prev1
        assign prev_vld = valid_d;
    end else begin : g_prevn
        assign prev_vld = vld_pipe[DEPTH-2];
    end

    always_comb begin
        last_vld_nxt = valid_q;
        if (flush[DEPTH-1])
            last_vld_nxt = 1'b0;
        else if (en)
            last_vld_nxt = prev_vld;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= 16'h0000;
            bubble_cnt <= 16'h0000;
        end else begin
            if (!en && valid_q)
                stall_cnt <= sat_inc16(stall_cnt);
            if (!last_vld_nxt)
                bubble_cnt <= sat_inc16(bubble_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_reg.sv
// tb_pipe_ctrl_reg: directed + random checks of pipe_ctrl_reg at DEPTH 1,2,3
// against a stage-array reference model built from the pipeline rules.
module tb_pipe_ctrl_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [15:0] d = '0;
    logic        valid_d = 1'b0;
    logic [0:0]  flush1 = '0;
    logic [1:0]  flush2 = '0;
    logic [2:0]  flush3 = '0;

    logic [15:0] q1, q2, q3;
    logic        vq1, vq2, vq3;
    logic [0:0]  sv1;
    logic [1:0]  sv2;
    logic [2:0]  sv3;
`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] sc [3];
    logic [15:0] bc [3];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_reg #(.WIDTH(16), .DEPTH(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush1), .d(d), .valid_d(valid_d),
        .q(q1), .valid_q(vq1), .stage_valid(sv1)
`ifdef PIPE_CTRL_STATS_EN
        , .stall_cnt(sc[0]), .bubble_cnt(bc[0])
`endif
    );

    pipe_ctrl_reg #(.WIDTH(16), .DEPTH(2)) u2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush2), .d(d), .valid_d(valid_d),
        .q(q2), .valid_q(vq2), .stage_valid(sv2)
`ifdef PIPE_CTRL_STATS_EN
        , .stall_cnt(sc[1]), .bubble_cnt(bc[1])
`endif
    );

    pipe_ctrl_reg #(.WIDTH(16), .DEPTH(3), .FLUSH_VAL(16'hDEAD)) u3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush3), .d(d), .valid_d(valid_d),
        .q(q3), .valid_q(vq3), .stage_valid(sv3)
`ifdef PIPE_CTRL_STATS_EN
        , .stall_cnt(sc[2]), .bubble_cnt(bc[2])
`endif
    );

    // Reference model: per DUT, an array of (data, valid) stages.
    int          dep [3] = '{1, 2, 3};
    logic [15:0] fvv [3] = '{16'h0000, 16'h0000, 16'hDEAD};
    logic [15:0] md  [3][4];
    logic        mv  [3][4];
    logic [15:0] msc [3];
    logic [15:0] mbc [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 4; k++) begin
                md[u][k] = fvv[u];
                mv[u][k] = 1'b0;
            end
            msc[u] = '0;
            mbc[u] = '0;
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One clock edge of the rules: flush wins, else advance on en, else hold.
    // Stages are walked from last to first so each reads its predecessor's
    // pre-edge contents.
    task automatic model_step(input logic [3:0] fl0, input logic [3:0] fl1, input logic [3:0] fl2);
        logic [3:0] fl [3];
        fl[0] = fl0; fl[1] = fl1; fl[2] = fl2;
        for (int u = 0; u < 3; u++) begin
            int   dd;
            logic last_pre;
            dd = dep[u];
            last_pre = mv[u][dd-1];
            for (int k = dd - 1; k >= 0; k--) begin
                logic [15:0] sd;
                logic        sv;
                if (k == 0) begin sd = d; sv = valid_d; end
                else begin sd = md[u][k-1]; sv = mv[u][k-1]; end
                if (fl[u][k]) begin
                    md[u][k] = fvv[u]; mv[u][k] = 1'b0;
                end else if (en) begin
                    md[u][k] = sv ? sd : fvv[u]; mv[u][k] = sv;
                end
            end
            if (!en && last_pre) msc[u] = sat(msc[u]);
            if (!mv[u][dd-1])    mbc[u] = sat(mbc[u]);
        end
    endtask

    task automatic check_all();
        chk("q_d1",   64'(q1),  64'(md[0][0]));
        chk("vq_d1",  64'(vq1), 64'(mv[0][0]));
        chk("sv_d1",  64'(sv1), 64'(mv[0][0]));
        chk("q_d2",   64'(q2),  64'(md[1][1]));
        chk("vq_d2",  64'(vq2), 64'(mv[1][1]));
        chk("sv_d2",  64'(sv2), 64'({mv[1][1], mv[1][0]}));
        chk("q_d3",   64'(q3),  64'(md[2][2]));
        chk("vq_d3",  64'(vq3), 64'(mv[2][2]));
        chk("sv_d3",  64'(sv3), 64'({mv[2][2], mv[2][1], mv[2][0]}));
`ifdef PIPE_CTRL_STATS_EN
        for (int u = 0; u < 3; u++) begin
            chk("stall_cnt",  64'(sc[u]), 64'(msc[u]));
            chk("bubble_cnt", 64'(bc[u]), 64'(mbc[u]));
        end
`endif
    endtask

    // Advance to the next edge, update the model with the inputs seen there,
    // and compare #1 after the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_step({3'b0, flush1}, {2'b0, flush2}, {1'b0, flush3});
        #1;
        check_all();
    endtask

    initial begin
        int n;
        model_reset();

        // Reset is asynchronous: outputs settle without any clock edge.
        #1 reset = 1'b1;
        #2 check_all();
        chk("rst_q3_flushval", 64'(q3), 64'h0000_0000_0000_DEAD);
        tick();
        tick();
        reset = 1'b0;

        // Advance, DEPTH=2: 1234 then 00AB, latency 2.
        en = 1'b1; d = 16'h1234; valid_d = 1'b1;
        tick();
        d = 16'h00AB;
        tick();
        chk("adv_q_e2",  64'(q2),  64'h1234);
        chk("adv_vq_e2", 64'(vq2), 64'h1);
        valid_d = 1'b0; d = 16'h7777;
        tick();
        chk("adv_q_e3",  64'(q2),  64'h00AB);

        // Stall, DEPTH=1: hold 5A5A across three stalled edges.
        d = 16'h5A5A; valid_d = 1'b1;
        tick();
        chk("stall_load", 64'(q1), 64'h5A5A);
        en = 1'b0; d = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 64'(q1), 64'h5A5A);
        end
        en = 1'b1;
        tick();
        chk("stall_release", 64'(q1), 64'hFFFF);

        // Flush over stall, DEPTH=2: B in stage 1, A in stage 0.
        d = 16'h0B0B; tick();
        d = 16'h0A0A; tick();
        en = 1'b0; flush2 = 2'b01;
        tick();
        chk("fos_sv",  64'(sv2), 64'b10);
        chk("fos_q",   64'(q2),  64'h0B0B);
        chk("fos_vq",  64'(vq2), 64'h1);
        flush2 = 2'b00; en = 1'b1; valid_d = 1'b0;
        tick();
        chk("fos_bubble_vq", 64'(vq2), 64'h0);
        chk("fos_bubble_q",  64'(q2),  64'h0000);

        // Flush of the last stage during advance, DEPTH=1 acts as sync clear.
        valid_d = 1'b1; d = 16'h4242; tick();
        flush1 = 1'b1; tick();
        chk("clr_d1_vq", 64'(vq1), 64'h0);
        flush1 = 1'b0;

        // Async reset mid-stream, then latency after release.
        valid_d = 1'b1; d = 16'hC0DE;
        tick(); tick(); tick();
        chk("pre_rst_vq", 64'(vq2), 64'h1);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        chk("mid_rst_q2",  64'(q2),  64'h0000);
        chk("mid_rst_vq2", 64'(vq2), 64'h0);
        #2 reset = 1'b0; valid_d = 1'b0;
        tick(); tick();
        valid_d = 1'b1; d = 16'h1357;
        n = 0;
        do begin
            tick();
            n++;
            valid_d = 1'b0;
        end while (!vq2 && n < 8);
        chk("rst_latency_d2", 64'(n), 64'd2);
        chk("rst_first_q2",   64'(q2), 64'h1357);

`ifdef PIPE_CTRL_STATS_EN
        // Saturation: preload FFFE, then three stalled edges with valid_q=1.
        valid_d = 1'b1; d = 16'h2468; en = 1'b1;
        tick();
        force u1.stall_cnt = 16'hFFFE;
        #1 release u1.stall_cnt;
        msc[0] = 16'hFFFE;
        en = 1'b0;
        tick(); tick(); tick();
        chk("stall_sat", 64'(sc[0]), 64'hFFFF);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            d       = 16'($urandom);
            valid_d = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 3) != 0);
            flush1  = ($urandom_range(0, 7) == 0);
            flush2  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            flush3  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0)};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
